// File: rtl/obi_wb_responder.sv
// OBI-to-Wishbone bridge: accepts one OBI request at a time, runs a single
// Wishbone classic cycle, and returns exactly one OBI response with an optional ack timeout.
module obi_wb_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        obi_req_i,
    output logic        obi_gnt_o,
    input  logic [31:0] obi_addr_i,
    input  logic        obi_we_i,
    input  logic [3:0]  obi_be_i,
    input  logic [31:0] obi_wdata_i,
    output logic        obi_rvalid_o,
    output logic [31:0] obi_rdata_o,
    output logic        obi_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    // Timeout fires in the BUS cycle whose increment would make the count reach TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cyc;
    logic              r_we;
    logic [3:0]        r_sel;
    logic [31:0]       r_adr;
    logic [31:0]       r_dat;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic              w_timeout;

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    // Grant is combinational so a request is accepted in the same cycle it is seen idle.
    assign obi_gnt_o    = (r_state == S_IDLE) && obi_req_i;
    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = r_cyc;
    assign wb_we_o      = r_we;
    assign wb_sel_o     = r_sel;
    assign wb_adr_o     = r_adr;
    assign wb_dat_o     = r_dat;
    assign obi_rvalid_o = r_rvalid;
    assign obi_rdata_o  = r_rdata;
    assign obi_err_o    = r_err;

    // NOTE: all state updates use non-blocking assignments so every register sees
    // pre-edge values; blocking here would make the result depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (obi_req_i) begin
                        r_adr   <= obi_addr_i;
                        r_we    <= obi_we_i;
                        r_sel   <= obi_be_i;
                        r_dat   <= obi_wdata_i;
                        r_cyc   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_BUS;
                    end
                end
                S_BUS: begin
                    // Error outranks ack, and either outranks a coincident timeout.
                    if (wb_err_i) begin
                        r_cyc    <= 1'b0;
                        r_rvalid <= 1'b1;
                        r_err    <= 1'b1;
                        r_rdata  <= '0;
                        r_state  <= S_RESP;
                    end else if (wb_ack_i) begin
                        r_cyc    <= 1'b0;
                        r_rvalid <= 1'b1;
                        r_err    <= 1'b0;
                        r_rdata  <= r_we ? 32'h0 : wb_dat_i;
                        r_state  <= S_RESP;
                    end else if (w_timeout) begin
                        r_cyc    <= 1'b0;
                        r_rvalid <= 1'b1;
                        r_err    <= 1'b1;
                        r_rdata  <= '0;
                        r_state  <= S_RESP;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_rvalid <= 1'b0;
                    r_err    <= 1'b0;
                    r_rdata  <= '0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_cyc    <= 1'b0;
                    r_rvalid <= 1'b0;
                    r_err    <= 1'b0;
                    r_rdata  <= '0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/obi_wb_responder.md
OBI_WB_RESPONDER -- requirements
Module: obi_wb_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max Wishbone cycles waited for ack/err; 0 = timeout disabled.
REQ-002 SHALL have ports, one per line:
  clk  input  1  sole clock, all state on rising edge
  rst_n  input  1  asynchronous active-low reset
  obi_req_i  input  1  OBI address-phase request
  obi_gnt_o  output  1  OBI grant
  obi_addr_i  input  32  byte address
  obi_we_i  input  1  1 = write
  obi_be_i  input  4  byte enables
  obi_wdata_i  input  32  write data
  obi_rvalid_o  output  1  OBI response valid
  obi_rdata_o  output  32  read data
  obi_err_o  output  1  response error, qualified by rvalid
  wb_cyc_o  output  1  Wishbone cycle
  wb_stb_o  output  1  Wishbone strobe
  wb_we_o  output  1  Wishbone write enable
  wb_sel_o  output  4  Wishbone byte select
  wb_adr_o  output  32  Wishbone address
  wb_dat_o  output  32  Wishbone write data
  wb_dat_i  input  32  Wishbone read data
  wb_ack_i  input  1  Wishbone acknowledge
  wb_err_i  input  1  Wishbone error

Function
REQ-003 SHALL implement a three-state FSM: IDLE, BUS, RESP.
REQ-004 In IDLE, obi_gnt_o SHALL equal obi_req_i (combinational); in BUS and RESP, obi_gnt_o SHALL be 0.
REQ-005 On a rising edge with state IDLE and obi_req_i=1, SHALL latch addr, we, be and wdata into wb_adr_o/wb_we_o/wb_sel_o/wb_dat_o registers, and SHALL enter BUS.
REQ-006 In BUS, wb_cyc_o and wb_stb_o SHALL both be 1; in IDLE and RESP both SHALL be 0.
REQ-007 wb_adr_o, wb_we_o, wb_sel_o and wb_dat_o SHALL hold their latched values from acceptance until the next acceptance.
REQ-008 In BUS, wb_ack_i=1 with wb_err_i=0 SHALL go to RESP; on a read, capture wb_dat_i into obi_rdata_o and set error to 0.
REQ-009 In BUS, wb_err_i=1 SHALL go to RESP with error=1 and rdata=0. It SHALL take priority over a simultaneous wb_ack_i.
REQ-010 Timeout counter:
  - cleared on entry to BUS, increments each BUS cycle without ack/err;
  - on reaching TIMEOUT_CYCLES (when nonzero), SHALL go to RESP with error=1, rdata=0;
  - ack/err on the same cycle as timeout SHALL win over timeout.
REQ-011 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1 bit; it SHALL saturate, never wrap.
REQ-012 In RESP, obi_rvalid_o SHALL be 1 for exactly one cycle, with obi_err_o valid; FSM SHALL then return to IDLE.
REQ-013 Writes SHALL also produce exactly one rvalid pulse; their obi_rdata_o SHALL be 0.
REQ-014 obi_rdata_o and obi_err_o SHALL be 0 whenever obi_rvalid_o=0.
REQ-015 At most one transaction SHALL be outstanding, and responses SHALL be in acceptance order.
REQ-016 Minimum latency SHALL be grant at cycle 0, cyc/stb at cycle 1, and rvalid at cycle 2 when ack arrives at cycle 1.
REQ-017 wb_ack_i/wb_err_i seen in IDLE or RESP SHALL be ignored.

Reset
REQ-018 rst_n=0 SHALL asynchronously force:
  - state IDLE, counter 0;
  - obi_rvalid_o, obi_err_o, obi_rdata_o = 0;
  - wb_cyc_o, wb_stb_o, wb_we_o = 0;
  - wb_sel_o, wb_adr_o, wb_dat_o = 0.
  obi_gnt_o then follows REQ-004.
REQ-019 Reset asserted mid-BUS SHALL abort the cycle, with cyc/stb low immediately and no rvalid issued afterwards.
REQ-020 Deassertion SHALL take effect on the first rising clk edge after rst_n=1.

Verification
REQ-021 Read, ack one cycle after cyc: req at addr 0x0000_1000, wb_dat_i=0xDEADBEEF -> gnt cycle 0, cyc/stb cycle 1, rvalid=1, rdata=0xDEADBEEF, err=0 at cycle 2.
REQ-022 Write, ack after 3 wait cycles: we=1, be=0x3, wdata=0x12345678 -> wb_we_o=1, wb_sel_o=0x3, wb_dat_o=0x12345678 held through all wait cycles; one rvalid with rdata=0, err=0.
REQ-023 Error priority: wb_ack_i and wb_err_i asserted together -> rvalid with err=1, rdata=0.
REQ-024 Timeout: TIMEOUT_CYCLES=4 with no ack -> cyc drops after 4 BUS cycles, then rvalid=1, err=1; late ack in IDLE ignored.
REQ-025 Back-to-back reads: obi_req_i held high -> gnt low in BUS/RESP, next grant in the cycle after rvalid, no overlapping Wishbone cycles.
REQ-026 Reset mid-BUS: rst_n low 2 cycles during BUS -> cyc/stb/rvalid 0 asynchronously; a fresh read after release completes normally.
